// File: rtl/ysyx_23060184_axi_rd_arbiter_pkg.sv
// Shared widths, FSM encodings and channel payloads for the IFU/LSU read-channel arbiter.
package ysyx_23060184_axi_rd_arbiter_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ID_WIDTH    = 4;
  localparam int unsigned ALEN        = 8;
  localparam int unsigned ASIZE       = 3;
  localparam int unsigned ABURST      = 2;
  localparam int unsigned ACERR_WIDTH = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [ALEN-1:0]       len;
    logic [ASIZE-1:0]      size;
    logic [ABURST-1:0]     burst;
  } ar_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [ACERR_WIDTH-1:0] resp;
    logic                   last;
  } r_t;

endpackage

// File: rtl/ysyx_23060184_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to prio.
module ysyx_23060184_rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       winner,
  output logic       any
);

  always_comb begin
    winner = prio;
    if (req == 2'b01) winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
  end

  assign any = |req;

endmodule

// File: rtl/ysyx_23060184_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between IFU (I) and LSU (D).
// One outstanding burst; AR is muxed and R is steered combinationally to the owner.
module ysyx_23060184_axi_rd_arbiter
  import ysyx_23060184_axi_rd_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_req,
  input  logic                   d_req,
  output logic                   i_grant,
  output logic                   d_grant,
  input  logic [DATA_WIDTH-1:0]  i_araddr,
  input  logic [ID_WIDTH-1:0]    i_arid,
  input  logic [ALEN-1:0]        i_arlen,
  input  logic [ASIZE-1:0]       i_arsize,
  input  logic [ABURST-1:0]      i_arburst,
  input  logic                   i_arvalid,
  output logic                   i_arready,
  output logic [DATA_WIDTH-1:0]  i_rdata,
  output logic [ACERR_WIDTH-1:0] i_rresp,
  output logic                   i_rvalid,
  output logic                   i_rlast,
  input  logic                   i_rready,
  input  logic [DATA_WIDTH-1:0]  d_araddr,
  input  logic [ID_WIDTH-1:0]    d_arid,
  input  logic [ALEN-1:0]        d_arlen,
  input  logic [ASIZE-1:0]       d_arsize,
  input  logic [ABURST-1:0]      d_arburst,
  input  logic                   d_arvalid,
  output logic                   d_arready,
  output logic [DATA_WIDTH-1:0]  d_rdata,
  output logic [ACERR_WIDTH-1:0] d_rresp,
  output logic                   d_rvalid,
  output logic                   d_rlast,
  input  logic                   d_rready,
  output logic [DATA_WIDTH-1:0]  m_araddr,
  output logic [ID_WIDTH-1:0]    m_arid,
  output logic [ALEN-1:0]        m_arlen,
  output logic [ASIZE-1:0]       m_arsize,
  output logic [ABURST-1:0]      m_arburst,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  input  logic [DATA_WIDTH-1:0]  m_rdata,
  input  logic [ACERR_WIDTH-1:0] m_rresp,
  input  logic                   m_rvalid,
  input  logic                   m_rlast,
  output logic                   m_rready
);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       prio_q, prio_d;

  logic pick_winner, pick_any;
  logic in_addr, in_data, own_i, own_d;
  logic own_req, own_arvalid, own_rready;
  ar_t  i_ar, d_ar, m_ar;
  r_t   m_r, i_r, d_r;

  ysyx_23060184_rr_pick2 u_pick (
    .req    ({d_req, i_req}),
    .prio   (prio_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  assign in_addr     = (state_q == ST_ADDR);
  assign in_data     = (state_q == ST_DATA);
  assign own_i       = (owner_q == MST_I);
  assign own_d       = (owner_q == MST_D);
  assign own_req     = own_d ? d_req     : i_req;
  assign own_arvalid = own_d ? d_arvalid : i_arvalid;
  assign own_rready  = own_d ? d_rready  : i_rready;

  // Next-state: arbitrate in IDLE, flip priority only when a burst really completes.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_winner;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_arvalid && m_arready) state_d = ST_DATA;
        else if (!own_req && !own_arvalid) state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (m_rvalid && m_rready && m_rlast) begin
          state_d = ST_IDLE;
          prio_d  = own_i ? MST_D : MST_I;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      owner_q <= MST_I;
      prio_q  <= MST_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  assign i_grant = (in_addr || in_data) && own_i;
  assign d_grant = (in_addr || in_data) && own_d;

  // AR mux: payload follows the owner, valid/ready only while in ADDR.
  assign i_ar = {i_araddr, i_arid, i_arlen, i_arsize, i_arburst};
  assign d_ar = {d_araddr, d_arid, d_arlen, d_arsize, d_arburst};
  assign m_ar = own_d ? d_ar : i_ar;
  assign {m_araddr, m_arid, m_arlen, m_arsize, m_arburst} = m_ar;
  assign m_arvalid = in_addr && own_arvalid;
  assign i_arready = in_addr && own_i && m_arready;
  assign d_arready = in_addr && own_d && m_arready;

  // R demux: non-owner sees an all-zero channel.
  assign m_r      = {m_rdata, m_rresp, m_rlast};
  assign i_r      = (in_data && own_i) ? m_r : '0;
  assign d_r      = (in_data && own_d) ? m_r : '0;
  assign {i_rdata, i_rresp, i_rlast} = i_r;
  assign {d_rdata, d_rresp, d_rlast} = d_r;
  assign i_rvalid = in_data && own_i && m_rvalid;
  assign d_rvalid = in_data && own_d && m_rvalid;
  assign m_rready = in_data && own_rready;

endmodule

// File: tb/tb_ysyx_23060184_axi_rd_arbiter.sv
// Scoreboard bench: bench-as-slave pushes each beat it drives, masters pop and compare on delivery.
module tb_ysyx_23060184_axi_rd_arbiter;
  import ysyx_23060184_axi_rd_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic i_req, d_req, i_grant, d_grant;
  logic [DATA_WIDTH-1:0]  i_araddr, d_araddr, m_araddr, i_rdata, d_rdata, m_rdata;
  logic [ID_WIDTH-1:0]    i_arid, d_arid, m_arid;
  logic [ALEN-1:0]        i_arlen, d_arlen, m_arlen;
  logic [ASIZE-1:0]       i_arsize, d_arsize, m_arsize;
  logic [ABURST-1:0]      i_arburst, d_arburst, m_arburst;
  logic                   i_arvalid, d_arvalid, m_arvalid, i_arready, d_arready, m_arready;
  logic [ACERR_WIDTH-1:0] i_rresp, d_rresp, m_rresp;
  logic                   i_rvalid, d_rvalid, m_rvalid, i_rlast, d_rlast, m_rlast;
  logic                   i_rready, d_rready, m_rready;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [ACERR_WIDTH-1:0] resp;
    logic                   last;
  } beat_t;

  beat_t iq[$];
  beat_t dq[$];
  int total = 0;
  int bad = 0;
  int i_beats = 0;
  int d_beats = 0;

  always #5 clk = ~clk;

  ysyx_23060184_axi_rd_arbiter dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .d_req(d_req), .i_grant(i_grant), .d_grant(d_grant),
    .i_araddr(i_araddr), .i_arid(i_arid), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arid(d_arid), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arburst(d_arburst), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rready(d_rready),
    .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs_vec();
    return {i_grant, d_grant, m_arvalid, m_rready, i_arready, d_arready, i_rvalid, d_rvalid};
  endfunction

  function automatic logic grant_of(input bit own);
    return own ? d_grant : i_grant;
  endfunction

  function automatic logic arready_of(input bit own);
    return own ? d_arready : i_arready;
  endfunction

  function automatic logic rbeat_of(input bit own);
    return own ? (d_rvalid & d_rready) : (i_rvalid & i_rready);
  endfunction

  function automatic logic rlast_of(input bit own);
    return own ? d_rlast : i_rlast;
  endfunction

  task automatic drive_m(input bit own, input logic req, input logic arv,
                         input logic [DATA_WIDTH-1:0] addr, input logic [ALEN-1:0] len);
    if (own) begin
      d_req = req; d_arvalid = arv; d_araddr = addr; d_arlen = len;
      d_arid = 4'h2; d_arsize = 3'd2; d_arburst = 2'b01;
    end else begin
      i_req = req; i_arvalid = arv; i_araddr = addr; i_arlen = len;
      i_arid = 4'h1; i_arsize = 3'd2; i_arburst = 2'b01;
    end
  endtask

  task automatic set_rready(input bit own, input logic v);
    if (own) d_rready = v;
    else i_rready = v;
  endtask

  // Master side: request, issue AR, accept beats until rlast, optionally stall rready for 2 cycles.
  task automatic master_burst(input bit own, input logic [DATA_WIDTH-1:0] addr,
                              input logic [ALEN-1:0] len, input bit stall);
    int  n;
    int  beats;
    bit  done;
    beats = 0;
    done  = 1'b0;
    drive_m(own, 1'b1, 1'b1, addr, len);
    set_rready(own, 1'b1);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (arready_of(own)) break;
      n++;
      if (n > 100) begin check("ar_timeout", 64'(arready_of(own)), 64'(1)); return; end
    end
    step();
    drive_m(own, 1'b1, 1'b0, addr, len);
    n = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      check(own ? "d_grant_hold" : "i_grant_hold", 64'(grant_of(own)), 64'(1));
      if (rbeat_of(own)) begin
        beats++;
        if (rlast_of(own)) done = 1'b1;
        if (stall && beats == 1 && !done) begin
          step(); set_rready(own, 1'b0);
          step(); step(); set_rready(own, 1'b1);
        end
      end
      if (n > 200) begin check("r_timeout", 64'(done), 64'(1)); return; end
    end
    step();
    drive_m(own, 1'b0, 1'b0, '0, '0);
  endtask

  // Slave side: accept AR (arready is held high), then return len+1 beats, optionally with gaps.
  task automatic slave_burst(input bit own, input logic [DATA_WIDTH-1:0] addr,
                             input logic [ALEN-1:0] len, input bit gaps,
                             input logic [ACERR_WIDTH-1:0] last_resp,
                             input logic [DATA_WIDTH-1:0] base);
    int    n;
    beat_t b;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (m_arvalid) break;
      n++;
      if (n > 100) begin check("slave_ar_timeout", 64'(m_arvalid), 64'(1)); return; end
    end
    check("m_araddr", 64'(m_araddr), 64'(addr));
    check("m_arlen", 64'(m_arlen), 64'(len));
    check("m_arid", 64'(m_arid), own ? 64'(2) : 64'(1));
    step();
    for (int k = 0; k <= int'(len); k++) begin
      if (gaps && (k % 2 == 1)) step();
      b.data = base + DATA_WIDTH'(k);
      b.resp = (k == int'(len)) ? last_resp : '0;
      b.last = (k == int'(len));
      m_rdata = b.data; m_rresp = b.resp; m_rlast = b.last; m_rvalid = 1'b1;
      if (own) dq.push_back(b);
      else iq.push_back(b);
      n = 0;
      while (1) begin
        @(negedge clk);
        if (m_rready) break;
        n++;
        if (n > 100) begin check("slave_r_timeout", 64'(m_rready), 64'(1)); return; end
      end
      step();
      m_rvalid = 1'b0; m_rlast = 1'b0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(); step();
    @(negedge clk);
    check("rst_outs", 64'(outs_vec()), 64'(0));
    step();
    rstn = 1'b1;
  endtask

  // Simultaneous request with no AR: check the winner, then drop both (prio must not move).
  task automatic tie_check(input bit exp_own);
    drive_m(1'b0, 1'b1, 1'b0, '0, '0);
    drive_m(1'b1, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    check("tie_idle", 64'({d_grant, i_grant}), 64'(0));
    @(negedge clk);
    check("tie_winner", 64'({d_grant, i_grant}), exp_own ? 64'(2) : 64'(1));
    check("tie_no_arvalid", 64'(m_arvalid), 64'(0));
    step();
    drive_m(1'b0, 1'b0, 1'b0, '0, '0);
    drive_m(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("tie_drop_idle", 64'({d_grant, i_grant}), 64'(0));
    step();
  endtask

  task automatic wait_i_last();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (i_rvalid && i_rready && i_rlast) return;
    end
    check("i_last_timeout", 64'(i_rlast), 64'(1));
  endtask

  // Delivery monitor: routing invariants plus scoreboard pops.
  always @(negedge clk) begin : mon
    beat_t e;
    if (i_grant || d_grant) check("grant_excl", 64'(i_grant & d_grant), 64'(0));
    if (m_rvalid && i_grant) begin
      check("m_rready_i", 64'(m_rready), 64'(i_rready));
      check("d_r_quiet", 64'({d_rvalid, d_rdata, d_rresp, d_rlast}), 64'(0));
    end
    if (m_rvalid && d_grant) begin
      check("m_rready_d", 64'(m_rready), 64'(d_rready));
      check("i_r_quiet", 64'({i_rvalid, i_rdata, i_rresp, i_rlast}), 64'(0));
    end
    if (i_rvalid && i_rready) begin
      if (iq.size() == 0) check("i_unexpected_beat", 64'(i_rvalid), 64'(0));
      else begin
        e = iq.pop_front();
        check("i_beat", 64'({i_rdata, i_rresp, i_rlast}), 64'(e));
        i_beats++;
      end
    end
    if (d_rvalid && d_rready) begin
      if (dq.size() == 0) check("d_unexpected_beat", 64'(d_rvalid), 64'(0));
      else begin
        e = dq.pop_front();
        check("d_beat", 64'({d_rdata, d_rresp, d_rlast}), 64'(e));
        d_beats++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    int i0;
    rstn = 1'b0;
    drive_m(1'b0, 1'b0, 1'b0, '0, '0);
    drive_m(1'b1, 1'b0, 1'b0, '0, '0);
    i_rready = 1'b0; d_rready = 1'b0;
    m_arready = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = '0;

    // Single fetch, then a tie must go to D
    do_reset();
    fork
      master_burst(1'b0, 32'h8000_0000, 8'd0, 1'b0);
      slave_burst(1'b0, 32'h8000_0000, 8'd0, 1'b0, 2'b00, 32'h0000_0413);
      begin
        @(negedge clk); check("t1_grant_c0", 64'(i_grant), 64'(0));
        @(negedge clk); check("t1_grant_c1", 64'(i_grant), 64'(1));
      end
    join
    @(negedge clk);
    check("t1_release", 64'({d_grant, i_grant}), 64'(0));
    check("t1_i_beats", 64'(i_beats), 64'(1));
    check("t1_d_beats", 64'(d_beats), 64'(0));
    step();
    tie_check(1'b1);

    // Simultaneous requests after reset: I first, D after one bubble, next tie back to I
    do_reset();
    fork
      master_burst(1'b0, 32'h8000_0100, 8'd1, 1'b0);
      master_burst(1'b1, 32'h8000_2000, 8'd1, 1'b0);
      begin
        slave_burst(1'b0, 32'h8000_0100, 8'd1, 1'b0, 2'b00, 32'h0000_1000);
        slave_burst(1'b1, 32'h8000_2000, 8'd1, 1'b0, 2'b00, 32'h0000_2000);
      end
      begin
        @(negedge clk); @(negedge clk);
        check("t2_i_first", 64'({d_grant, i_grant}), 64'(1));
        wait_i_last();
        @(negedge clk); check("t2_bubble", 64'(d_grant), 64'(0));
        @(negedge clk); check("t2_d_grant", 64'(d_grant), 64'(1));
      end
    join
    @(negedge clk);
    check("t2_release", 64'({d_grant, i_grant}), 64'(0));
    step();
    tie_check(1'b0);

    // D burst of 4 with slave gaps and a 2-cycle rready stall
    d0 = d_beats;
    fork
      master_burst(1'b1, 32'h8000_3000, 8'd3, 1'b1);
      slave_burst(1'b1, 32'h8000_3000, 8'd3, 1'b1, 2'b00, 32'h0000_3000);
    join
    check("t3_beats", 64'(d_beats - d0), 64'(4));
    @(negedge clk);
    check("t3_release", 64'(d_grant), 64'(0));
    step();

    // Owner drops request in ADDR without arvalid
    do_reset();
    drive_m(1'b0, 1'b1, 1'b0, 32'h8000_4000, 8'd0);
    @(negedge clk);
    @(negedge clk);
    check("t4_grant", 64'(i_grant), 64'(1));
    check("t4_no_arvalid", 64'(m_arvalid), 64'(0));
    check("t4_arready", 64'({i_arready, d_arready}), 64'(2));
    step();
    drive_m(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    check("t4_idle", 64'({d_grant, i_grant, m_arvalid}), 64'(0));
    step();
    tie_check(1'b0);

    // Error response on D's last beat passes through, grant releases
    d0 = d_beats;
    fork
      master_burst(1'b1, 32'h8000_5000, 8'd1, 1'b0);
      slave_burst(1'b1, 32'h8000_5000, 8'd1, 1'b0, 2'b10, 32'h0000_5000);
    join
    check("t5_beats", 64'(d_beats - d0), 64'(2));
    @(negedge clk);
    check("t5_release", 64'(d_grant), 64'(0));
    step();

    // Reset in the middle of a D burst
    drive_m(1'b1, 1'b1, 1'b1, 32'h8000_6000, 8'd3);
    set_rready(1'b1, 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_arvalid) break;
    end
    check("t6_arvalid", 64'(m_arvalid), 64'(1));
    step();
    drive_m(1'b1, 1'b1, 1'b0, 32'h8000_6000, 8'd3);
    m_rdata = 32'h0000_6000; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b1;
    dq.push_back(beat_t'({32'h0000_6000, 2'b00, 1'b0}));
    rstn = 1'b0;
    @(negedge clk);
    check("t6_data_route", 64'(d_rvalid), 64'(1));
    step();
    @(negedge clk);
    check("t6_rst_outs", 64'(outs_vec()), 64'(0));
    step();
    m_rvalid = 1'b0;
    drive_m(1'b1, 1'b0, 1'b0, '0, '0);
    step();
    rstn = 1'b1;
    i0 = i_beats;
    fork
      master_burst(1'b0, 32'h8000_7000, 8'd0, 1'b0);
      slave_burst(1'b0, 32'h8000_7000, 8'd0, 1'b0, 2'b00, 32'h0000_7000);
      begin
        @(negedge clk); check("t6_post_c0", 64'(i_grant), 64'(0));
        @(negedge clk); check("t6_post_c1", 64'(i_grant), 64'(1));
      end
    join
    check("t6_post_beats", 64'(i_beats - i0), 64'(1));
    step();

    check("iq_drained", 64'(iq.size()), 64'(0));
    check("dq_drained", 64'(dq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
